mult_limb_sequencer: RTL

Multi-cycle wide-operand multiplier built around the existing DSP-style `MULT` block. It splits two `WIDTH`-bit unsigned operands into `LIMB`-bit limbs and issues one limb pair per cycle to a single `MULT` instance. It then accumulates the delayed partial products, shifted into place, to form the full `2*WIDTH`-bit product. It sits directly upstream of `MULT`, feeding it, and directly downstream, consuming `P`. Field-arithmetic reduction for ed25519 consumes its output.

---
 rtl/mult_seq_pkg.sv | 23 ++
 rtl/mult_limb_sequencer_mult.sv | 52 +++++
 rtl/mult_limb_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the limb-serial wide multiplier.
package mult_seq_pkg;

  localparam int DEF_WIDTH   = 256;
  localparam int DEF_LIMB    = 17;
  localparam int DEF_LATENCY = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int n_limbs(input int width, input int limb);
    return ceil_div(width, limb);
  endfunction

  // Full product of two zero-extended N-limb operands.
  function automatic int acc_width(input int width, input int limb);
    return 2 * limb * n_limbs(width, limb);
  endfunction

endpackage

// File: rtl/mult_limb_sequencer_mult.sv
// Behavioural stand-in for the DSP-style MULT block: unsigned A*B, LATENCY registers deep.
module MULT #(
  parameter string DEVICE  = "7SERIES",
  parameter int    WIDTH_A = 17,
  parameter int    WIDTH_B = 17,
  parameter int    LATENCY = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic [WIDTH_A-1:0]         A,
  input  logic [WIDTH_B-1:0]         B,
  output logic [WIDTH_A+WIDTH_B-1:0] P
);
  localparam int PW = WIDTH_A + WIDTH_B;

  generate
    if (DEVICE == "7SERIES" && LATENCY >= 2) begin : g_inreg
      // Input registers first, remaining stages after the multiply.
      logic [WIDTH_A-1:0]         a_r;
      logic [WIDTH_B-1:0]         b_r;
      logic [LATENCY-2:0][PW-1:0] p_r;

      always_ff @(posedge CLK) begin
        if (RST) begin
          a_r <= '0;
          b_r <= '0;
          p_r <= '0;
        end else if (CE) begin
          a_r    <= A;
          b_r    <= B;
          p_r[0] <= PW'(a_r) * PW'(b_r);
          for (int s = 1; s < LATENCY - 1; s++) p_r[s] <= p_r[s-1];
        end
      end
      assign P = p_r[LATENCY-2];
    end else begin : g_outreg
      logic [LATENCY-1:0][PW-1:0] p_r;

      always_ff @(posedge CLK) begin
        if (RST) begin
          p_r <= '0;
        end else if (CE) begin
          p_r[0] <= PW'(A) * PW'(B);
          for (int s = 1; s < LATENCY; s++) p_r[s] <= p_r[s-1];
        end
      end
      assign P = p_r[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/mult_limb_sequencer.sv
// Wide unsigned multiplier: streams N*N limb pairs through one MULT and
// accumulates the shifted partial products into a 2*WIDTH-bit result.
module mult_limb_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LIMB    = DEF_LIMB,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   OP_A,
  input  logic [WIDTH-1:0]   OP_B,
  output logic               READY,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PROD
);
  localparam int N     = n_limbs(WIDTH, LIMB);
  localparam int EXT_W = N * LIMB;
  localparam int ACC_W = acc_width(WIDTH, LIMB);
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam int PW    = 2 * LIMB;

  state_t                     state, nxt;
  logic [EXT_W-1:0]           op_a_q, op_b_q;
  logic [CW-1:0]              i_q, j_q;
  logic [LATENCY-1:0]         vld_pipe;
  logic [LATENCY-1:0][KW-1:0] k_pipe;
  logic [ACC_W-1:0]           acc;
  logic [2*WIDTH-1:0]         prod_q;
  logic [LIMB-1:0]            mul_a, mul_b;
  logic [PW-1:0]              mul_p;
  logic [KW-1:0]              k_in, k_out;
  logic                       accept, issue, last_pair, pipe_empty;
  logic                       unused_acc_hi;

  assign accept     = (state == S_IDLE) && START;
  assign issue      = (state == S_ISSUE);
  assign last_pair  = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
  assign pipe_empty = ~|vld_pipe;
  assign mul_a      = op_a_q[i_q*LIMB +: LIMB];
  assign mul_b      = op_b_q[j_q*LIMB +: LIMB];
  assign k_in       = KW'(i_q) + KW'(j_q);
  assign k_out      = k_pipe[LATENCY-1];

  assign READY = (state == S_IDLE);
  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_DONE);
  assign PROD  = prod_q;

  // The top limb-pair columns only ever hold zero for a WIDTH-bit product.
  assign unused_acc_hi = ^acc[ACC_W-1:2*WIDTH];

  MULT #(
    .DEVICE ("7SERIES"),
    .WIDTH_A(LIMB),
    .WIDTH_B(LIMB),
    .LATENCY(LATENCY)
  ) u_mult (
    .CLK(CLK),
    .RST(1'b0),
    .CE (1'b1),
    .A  (mul_a),
    .B  (mul_b),
    .P  (mul_p)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (START)      nxt = S_ISSUE;
      S_ISSUE: if (last_pair)  nxt = S_DRAIN;
      // Leave only once the final tagged product has been folded in.
      S_DRAIN: if (pipe_empty) nxt = S_DONE;
      S_DONE:                  nxt = S_IDLE;
      default:                 nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_a_q <= '0;
      op_b_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (accept) begin
      op_a_q <= EXT_W'(OP_A);
      op_b_q <= EXT_W'(OP_B);
      i_q    <= '0;
      j_q    <= '0;
    end else if (issue) begin
      if (j_q == CW'(N - 1)) begin
        j_q <= '0;
        i_q <= last_pair ? '0 : i_q + 1'b1;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  // Tag pipe mirrors MULT latency so each P arrives with its column index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      k_pipe   <= '0;
    end else begin
      vld_pipe[0] <= issue;
      k_pipe[0]   <= k_in;
      for (int s = 1; s < LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        k_pipe[s]   <= k_pipe[s-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                       acc <= '0;
    else if (accept)                  acc <= '0;
    else if (vld_pipe[LATENCY-1])     acc <= acc + (ACC_W'(mul_p) << (LIMB * k_out));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                               prod_q <= '0;
    else if (state == S_DRAIN && pipe_empty)  prod_q <= acc[2*WIDTH-1:0];
  end

endmodule
